// File: rtl/hit_out_fifo.sv
// hit_out_fifo: first-word fall-through buffer between the rasterizer's
// sample-test stage and the z-buffer/frame-buffer writer. Issues an
// active-low halt early enough that hits already in flight always fit,
// counts accepted hits and flags any dropped hit until reset.
module hit_out_fifo #(
   parameter int SIGFIG      = 24,
   parameter int AXIS        = 3,
   parameter int COLORS      = 3,
   parameter int DEPTH       = 16,
   parameter int HALT_MARGIN = 6,
   parameter int CNT_W       = 32
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic signed [AXIS-1:0][SIGFIG-1:0]     hit_R18S,
   input  logic        [COLORS-1:0][SIGFIG-1:0]   color_R18U,
   input  logic                                   hit_valid_R18H,
   output logic                                   halt_RnnnnL,
   output logic        [AXIS-1:0][SIGFIG-1:0]     out_hit_S,
   output logic        [COLORS-1:0][SIGFIG-1:0]   out_color_U,
   output logic                                   out_valid_H,
   input  logic                                   out_ready_H,
   output logic        [$clog2(DEPTH):0]          count_U,
   output logic        [CNT_W-1:0]                hit_total_U,
   output logic                                   overflow_H
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0]    HALT_LVL = CW'(DEPTH - HALT_MARGIN);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1'b1);
   localparam logic [PW-1:0]    PTR_ONE  = PW'(1'b1);
   localparam logic [CNT_W-1:0] TOT_ONE  = CNT_W'(1'b1);

   typedef logic [AXIS-1:0][SIGFIG-1:0]   hit_t;
   typedef logic [COLORS-1:0][SIGFIG-1:0] color_t;

   hit_t          hit_mem_q   [DEPTH];
   hit_t          hit_mem_d   [DEPTH];
   color_t        color_mem_q [DEPTH];
   color_t        color_mem_d [DEPTH];

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CNT_W-1:0] hit_total_q, hit_total_d;
   logic             overflow_q, overflow_d;
   logic             halt_q, halt_d;

   logic             pop_s;
   logic             full_s;
   logic             push_acc_s;
   logic             drop_s;

   // Handshake decode: a pop needs a valid head, a push into a full FIFO
   // survives only if the head leaves in the same cycle.
   always_comb begin
      pop_s      = 1'b0;
      full_s     = 1'b0;
      push_acc_s = 1'b0;
      drop_s     = 1'b0;
      pop_s      = (count_q != {CW{1'b0}}) && out_ready_H;
      full_s     = (count_q == FULL_CNT);
      push_acc_s = hit_valid_R18H && (!full_s || pop_s);
      drop_s     = hit_valid_R18H && full_s && !pop_s;
   end

   // Next-state for pointers, occupancy, statistics and the halt flop.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      hit_total_d = hit_total_q;
      overflow_d  = overflow_q;
      halt_d      = halt_q;

      if (push_acc_s) begin
         wr_ptr_d    = wr_ptr_q + PTR_ONE;
         hit_total_d = hit_total_q + TOT_ONE;
      end else begin
         wr_ptr_d    = wr_ptr_q;
         hit_total_d = hit_total_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_acc_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      overflow_d = overflow_q | drop_s;
      // Halt is based on next occupancy so it lands together with the
      // count that crosses the threshold.
      halt_d     = !(count_d >= HALT_LVL);
   end

   // Storage write: only the slot under wr_ptr changes on an accepted push.
   always_comb begin
      hit_mem_d   = hit_mem_q;
      color_mem_d = color_mem_q;
      if (push_acc_s) begin
         hit_mem_d[wr_ptr_q]   = hit_t'(hit_R18S);
         color_mem_d[wr_ptr_q] = color_R18U;
      end else begin
         hit_mem_d   = hit_mem_q;
         color_mem_d = color_mem_q;
      end
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= {PW{1'b0}};
         rd_ptr_q    <= {PW{1'b0}};
         count_q     <= {CW{1'b0}};
         hit_total_q <= {CNT_W{1'b0}};
         overflow_q  <= 1'b0;
         halt_q      <= 1'b1;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         hit_total_q <= hit_total_d;
         overflow_q  <= overflow_d;
         halt_q      <= halt_d;
      end
   end

   // Entry array; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      hit_mem_q   <= hit_mem_d;
      color_mem_q <= color_mem_d;
   end

   // Fall-through outputs straight from registered state.
   always_comb begin
      out_hit_S   = hit_mem_q[rd_ptr_q];
      out_color_U = color_mem_q[rd_ptr_q];
      out_valid_H = (count_q != {CW{1'b0}});
      count_U     = count_q;
      hit_total_U = hit_total_q;
      overflow_H  = overflow_q;
      halt_RnnnnL = halt_q;
   end

endmodule
